// File: rtl/if_predecode.sv
// ---------------------------------------------------------------------------
// if_predecode
//
// Fetch-stage predecoder between the instruction fetch buffer and the return
// address stack. Each fetched MIPS32 word is predecoded to produce RAS
// push/pop requests (push address = PC+8). Once the delay slot of a predicted
// jump (J, JAL, JR $31) has been accepted, a predicted-PC redirect is issued:
// direct jumps redirect to their computed target; JR $31 waits for the RAS to
// present the popped address and then redirects with pred_use_ras_o set.
// Accepted words pass downstream through a 1-entry valid/ready register.
//
// Parameters
//   RAS_LAT          cycles from a ras_pop_o pulse until the RAS output is valid
//
// Ports
//   clk              clock, rising edge
//   rst              asynchronous reset, active low
//   flush_i          synchronous pipeline flush, highest priority
//   inst_valid_i     fetched word valid
//   inst_ready_o     predecoder can accept
//   inst_pc_i        PC of fetched word
//   inst_i           fetched word
//   out_valid_o      downstream entry valid
//   out_ready_i      downstream accepts
//   out_pc_o         registered PC
//   out_inst_o       registered instruction
//   out_ds_o         entry is the delay slot of a predicted jump
//   ras_push_o       1-cycle push request to the RAS
//   ras_pop_o        1-cycle pop request to the RAS
//   ras_push_addr_o  return address to push (PC+8)
//   pred_redirect_o  1-cycle request to refetch from the predicted target
//   pred_use_ras_o   with redirect: target is the RAS output
//   pred_target_o    direct jump target (0 when no redirect)
// ---------------------------------------------------------------------------
module if_predecode #(
  parameter int unsigned RAS_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        inst_valid_i,
  output logic        inst_ready_o,
  input  logic [31:0] inst_pc_i,
  input  logic [31:0] inst_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_inst_o,
  output logic        out_ds_o,
  output logic        ras_push_o,
  output logic        ras_pop_o,
  output logic [31:0] ras_push_addr_o,
  output logic        pred_redirect_o,
  output logic        pred_use_ras_o,
  output logic [31:0] pred_target_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DS_PEND  = 2'd1,
    RET_WAIT = 2'd2
  } state_t;

  localparam int unsigned          CNT_W    = $clog2(RAS_LAT + 2) + 1;
  localparam logic [CNT_W-1:0]     CNT_FIRE = CNT_W'(RAS_LAT);
  localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(RAS_LAT + 1);

  state_t state, state_next;

  // Instruction fields
  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign funct = inst_i[5:0];

  logic is_special, is_j, is_jal, is_jr31, is_jalr, is_bal;
  logic do_push, do_pop, pred_jump;

  assign is_special = (op == 6'b000000);
  assign is_j       = (op == 6'b000010);
  assign is_jal     = (op == 6'b000011);
  assign is_jr31    = is_special & (funct == 6'b001000) & (rs == 5'd31);
  assign is_jalr    = is_special & (funct == 6'b001001);
  assign is_bal     = (op == 6'b000001) & (rt[4:1] == 4'b1000);

  assign do_push    = is_jal | is_jalr | is_bal;
  assign do_pop     = is_jr31 | (is_jalr & (rs == 5'd31));
  assign pred_jump  = is_j | is_jal | is_jr31;

  // High nibble of pc+4: carry into bit 28 happens only when pc[27:2] are all
  // ones, so the full 32-bit pc+4 sum is never needed.
  logic [3:0]  pc4_hi;
  logic [31:0] pc_plus8;
  logic [31:0] jump_target;

  assign pc4_hi      = inst_pc_i[31:28] + {3'b000, &inst_pc_i[27:2]};
  assign pc_plus8    = inst_pc_i + 32'd8;
  assign jump_target = {pc4_hi, inst_i[25:0], 2'b00};

  // Handshake
  logic ready;
  logic acc;
  logic dec_en;

  assign ready        = !flush_i & (!out_valid_o | out_ready_i) & (state != RET_WAIT);
  assign inst_ready_o = ready;
  assign acc          = inst_valid_i & ready;
  // Only words accepted in IDLE are decoded; a delay slot never is.
  assign dec_en       = acc & (state == IDLE);

  // Latched predicted-jump information and cycles-since-pop counter
  logic [31:0]      tgt_q;
  logic             use_ras_q;
  logic [CNT_W-1:0] cnt_q;

  // Next values for the registered redirect outputs
  logic        redirect_next;
  logic        use_ras_next;
  logic [31:0] target_next;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and redirect decisions
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    redirect_next = 1'b0;
    use_ras_next  = 1'b0;
    target_next   = '0;

    unique case (state)
      IDLE: begin
        if (dec_en & pred_jump) begin
          state_next = DS_PEND;
        end
      end

      DS_PEND: begin
        if (acc) begin
          if (use_ras_q) begin
            state_next = RET_WAIT;
          end else begin
            redirect_next = 1'b1;
            target_next   = tgt_q;
            state_next    = IDLE;
          end
        end
      end

      RET_WAIT: begin
        // The redirect register is high only in the cycle the return redirect
        // is presented; leave after that cycle so ready stays low through it.
        if (pred_redirect_o) begin
          state_next = IDLE;
        end else if (cnt_q >= CNT_FIRE) begin
          redirect_next = 1'b1;
          use_ras_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (flush_i) begin
      state_next    = IDLE;
      redirect_next = 1'b0;
      use_ras_next  = 1'b0;
      target_next   = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Predicted-jump latch and cycles-since-pop counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_q     <= '0;
      use_ras_q <= 1'b0;
      cnt_q     <= '0;
    end else if (flush_i) begin
      tgt_q     <= '0;
      use_ras_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (dec_en & pred_jump) begin
        tgt_q     <= jump_target;
        use_ras_q <= is_jr31;
      end
      // Counter reads 0 in the cycle the pop pulse is visible.
      if (dec_en & is_jr31) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Downstream 1-entry register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_o <= 1'b0;
      out_pc_o    <= '0;
      out_inst_o  <= '0;
      out_ds_o    <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      out_ds_o    <= 1'b0;
    end else if (acc) begin
      out_valid_o <= 1'b1;
      out_pc_o    <= inst_pc_i;
      out_inst_o  <= inst_i;
      out_ds_o    <= (state == DS_PEND);
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
      out_ds_o    <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // RAS requests: one pulse per decoded instruction, the cycle after accept
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ras_push_o      <= 1'b0;
      ras_pop_o       <= 1'b0;
      ras_push_addr_o <= '0;
    end else if (flush_i) begin
      ras_push_o      <= 1'b0;
      ras_pop_o       <= 1'b0;
      ras_push_addr_o <= '0;
    end else begin
      ras_push_o      <= dec_en & do_push;
      ras_pop_o       <= dec_en & do_pop;
      ras_push_addr_o <= (dec_en & do_push) ? pc_plus8 : '0;
    end
  end

  // -------------------------------------------------------------------------
  // Redirect outputs (zero outside the redirect cycle)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_redirect_o <= 1'b0;
      pred_use_ras_o  <= 1'b0;
      pred_target_o   <= '0;
    end else begin
      pred_redirect_o <= redirect_next;
      pred_use_ras_o  <= use_ras_next;
      pred_target_o   <= target_next;
    end
  end

endmodule

// File: tb/tb_if_predecode.sv
module tb_if_predecode;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic [31:0] inst_pc_i;
  logic [31:0] inst_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;
  logic        out_ds_o;
  logic        ras_push_o;
  logic        ras_pop_o;
  logic [31:0] ras_push_addr_o;
  logic        pred_redirect_o;
  logic        pred_use_ras_o;
  logic [31:0] pred_target_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_predecode #(.RAS_LAT(2)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_pc_i(inst_pc_i), .inst_i(inst_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_inst_o(out_inst_o), .out_ds_o(out_ds_o),
    .ras_push_o(ras_push_o), .ras_pop_o(ras_pop_o), .ras_push_addr_o(ras_push_addr_o),
    .pred_redirect_o(pred_redirect_o), .pred_use_ras_o(pred_use_ras_o),
    .pred_target_o(pred_target_o)
  );

  // Monitor for the randomized scenario
  logic        mon_on = 1'b0;
  logic [64:0] got_out[$];
  logic [31:0] got_push[$];
  logic [32:0] got_redir[$];
  int          got_pops = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (out_valid_o && out_ready_i) got_out.push_back({out_ds_o, out_pc_o, out_inst_o});
      if (ras_push_o) got_push.push_back(ras_push_addr_o);
      if (ras_pop_o) got_pops++;
      if (pred_redirect_o) got_redir.push_back({pred_use_ras_o, pred_use_ras_o ? 32'h0 : pred_target_o});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] w);
    inst_valid_i = v;
    inst_pc_i    = pc;
    inst_i       = w;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    #3;
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid_o); end
    checks++; if (out_ds_o !== 1'b0) begin failures++; $display("FAIL reset_out_ds got=%0b exp=0", out_ds_o); end
    checks++; if (out_pc_o !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc_o); end
    checks++; if (out_inst_o !== 32'h0) begin failures++; $display("FAIL reset_out_inst got=%h exp=0", out_inst_o); end
    checks++; if (ras_push_o !== 1'b0 || ras_pop_o !== 1'b0) begin failures++; $display("FAIL reset_ras got=%0b%0b exp=00", ras_push_o, ras_pop_o); end
    checks++; if (ras_push_addr_o !== 32'h0) begin failures++; $display("FAIL reset_push_addr got=%h exp=0", ras_push_addr_o); end
    checks++; if (pred_redirect_o !== 1'b0 || pred_use_ras_o !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%0b%0b exp=00", pred_redirect_o, pred_use_ras_o); end
    checks++; if (pred_target_o !== 32'h0) begin failures++; $display("FAIL reset_target got=%h exp=0", pred_target_o); end
    checks++; if (inst_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", inst_ready_o); end
    flush_i = 1'b1; #1;
    checks++; if (inst_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready_flush got=%0b exp=0", inst_ready_o); end
    flush_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    cyc();
  endtask

  // JAL 0x80000100 idx 0x123: push 0x80000108, redirect to 0x8000048C after the delay slot
  task automatic test_jal();
    drive(1'b1, 32'h80000100, 32'h0C000123); #1;
    checks++; if (inst_ready_o !== 1'b1) begin failures++; $display("FAIL jal_ready got=%0b exp=1", inst_ready_o); end
    cyc();
    checks++; if (ras_push_o !== 1'b1) begin failures++; $display("FAIL jal_push got=%0b exp=1", ras_push_o); end
    checks++; if (ras_push_addr_o !== 32'h80000108) begin failures++; $display("FAIL jal_push_addr got=%h exp=80000108", ras_push_addr_o); end
    checks++; if (pred_redirect_o !== 1'b0) begin failures++; $display("FAIL jal_early_redirect got=%0b exp=0", pred_redirect_o); end
    checks++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h80000100 || out_inst_o !== 32'h0C000123 || out_ds_o !== 1'b0)
      begin failures++; $display("FAIL jal_out got=%0b/%h/%h/%0b exp=1/80000100/0c000123/0", out_valid_o, out_pc_o, out_inst_o, out_ds_o); end
    drive(1'b1, 32'h80000104, 32'h00000000); #1;
    checks++; if (inst_ready_o !== 1'b1) begin failures++; $display("FAIL jal_ds_ready got=%0b exp=1", inst_ready_o); end
    cyc();
    checks++; if (ras_push_o !== 1'b0) begin failures++; $display("FAIL jal_push_once got=%0b exp=0", ras_push_o); end
    checks++; if (pred_redirect_o !== 1'b1 || pred_use_ras_o !== 1'b0) begin failures++; $display("FAIL jal_redirect got=%0b use_ras=%0b exp=1/0", pred_redirect_o, pred_use_ras_o); end
    checks++; if (pred_target_o !== 32'h8000048C) begin failures++; $display("FAIL jal_target got=%h exp=8000048c", pred_target_o); end
    checks++; if (out_ds_o !== 1'b1 || out_pc_o !== 32'h80000104) begin failures++; $display("FAIL jal_ds_out got=%0b/%h exp=1/80000104", out_ds_o, out_pc_o); end
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    checks++; if (pred_redirect_o !== 1'b0 || pred_target_o !== 32'h0) begin failures++; $display("FAIL jal_redirect_end got=%0b/%h exp=0/0", pred_redirect_o, pred_target_o); end
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL jal_drain got=%0b exp=0", out_valid_o); end
  endtask

  // JR $31 in N, delay slot N+1: pop N+1, ready low from N+2, redirect N+4, ready N+5
  task automatic test_jr();
    drive(1'b1, 32'h00001000, 32'h03E00008);
    cyc();
    checks++; if (ras_pop_o !== 1'b1 || ras_push_o !== 1'b0) begin failures++; $display("FAIL jr_pop got=pop%0b push%0b exp=pop1 push0", ras_pop_o, ras_push_o); end
    drive(1'b1, 32'h00001004, 32'h00000000);
    cyc();
    checks++; if (ras_pop_o !== 1'b0) begin failures++; $display("FAIL jr_pop_once got=%0b exp=0", ras_pop_o); end
    drive(1'b1, 32'h00001008, 32'h24010001); #1;
    checks++; if (inst_ready_o !== 1'b0) begin failures++; $display("FAIL jr_ready_n2 got=%0b exp=0", inst_ready_o); end
    cyc();
    checks++; if (inst_ready_o !== 1'b0 || pred_redirect_o !== 1'b0) begin failures++; $display("FAIL jr_n3 got=ready%0b redir%0b exp=0/0", inst_ready_o, pred_redirect_o); end
    cyc();
    checks++; if (pred_redirect_o !== 1'b1 || pred_use_ras_o !== 1'b1) begin failures++; $display("FAIL jr_redirect got=%0b use_ras=%0b exp=1/1", pred_redirect_o, pred_use_ras_o); end
    checks++; if (inst_ready_o !== 1'b0) begin failures++; $display("FAIL jr_ready_n4 got=%0b exp=0", inst_ready_o); end
    cyc();
    checks++; if (inst_ready_o !== 1'b1 || pred_redirect_o !== 1'b0) begin failures++; $display("FAIL jr_n5 got=ready%0b redir%0b exp=1/0", inst_ready_o, pred_redirect_o); end
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (out_pc_o !== 32'h00001008 || out_ds_o !== 1'b0) begin failures++; $display("FAIL jr_next_word got=%h/%0b exp=00001008/0", out_pc_o, out_ds_o); end
    cyc();
  endtask

  // JALR $31 then BGEZAL at 0x00400010
  task automatic test_jalr_bal();
    drive(1'b1, 32'h00400008, 32'h03E0F809);
    cyc();
    checks++; if (ras_push_o !== 1'b1 || ras_pop_o !== 1'b1) begin failures++; $display("FAIL jalr_pulses got=push%0b pop%0b exp=1/1", ras_push_o, ras_pop_o); end
    checks++; if (ras_push_addr_o !== 32'h00400010) begin failures++; $display("FAIL jalr_addr got=%h exp=00400010", ras_push_addr_o); end
    drive(1'b1, 32'h00400010, 32'h04B10010);
    cyc();
    checks++; if (ras_push_o !== 1'b1 || ras_pop_o !== 1'b0) begin failures++; $display("FAIL bgezal_pulses got=push%0b pop%0b exp=1/0", ras_push_o, ras_pop_o); end
    checks++; if (ras_push_addr_o !== 32'h00400018) begin failures++; $display("FAIL bgezal_addr got=%h exp=00400018", ras_push_addr_o); end
    checks++; if (pred_redirect_o !== 1'b0 || out_ds_o !== 1'b0) begin failures++; $display("FAIL jalr_no_redirect got=redir%0b ds%0b exp=0/0", pred_redirect_o, out_ds_o); end
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    checks++; if (ras_push_o !== 1'b0 || pred_redirect_o !== 1'b0) begin failures++; $display("FAIL bgezal_after got=push%0b redir%0b exp=0/0", ras_push_o, pred_redirect_o); end
  endtask

  // JAL held for 3 cycles by out_ready_i=0
  task automatic test_backpressure();
    int pushes;
    pushes = 0;
    drive(1'b1, 32'h00002000, 32'h0C000040);
    cyc();
    pushes += int'(ras_push_o);
    out_ready_i = 1'b0;
    drive(1'b1, 32'h00002004, 32'h00000000); #1;
    checks++; if (inst_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_first got=%0b exp=0", inst_ready_o); end
    for (int i = 0; i < 2; i++) begin
      cyc();
      pushes += int'(ras_push_o);
      checks++; if (out_valid_o !== 1'b1 || out_pc_o !== 32'h00002000 || out_inst_o !== 32'h0C000040 || inst_ready_o !== 1'b0)
        begin failures++; $display("FAIL bp_hold got=%0b/%h/%h ready=%0b exp=1/00002000/0c000040 ready=0", out_valid_o, out_pc_o, out_inst_o, inst_ready_o); end
    end
    cyc();
    pushes += int'(ras_push_o);
    out_ready_i = 1'b1; #1;
    checks++; if (inst_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_rise got=%0b exp=1", inst_ready_o); end
    cyc();
    pushes += int'(ras_push_o);
    checks++; if (out_pc_o !== 32'h00002004 || out_ds_o !== 1'b1) begin failures++; $display("FAIL bp_next_taken got=%h/%0b exp=00002004/1", out_pc_o, out_ds_o); end
    checks++; if (pred_redirect_o !== 1'b1 || pred_target_o !== 32'h00000100) begin failures++; $display("FAIL bp_redirect got=%0b/%h exp=1/00000100", pred_redirect_o, pred_target_o); end
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    pushes += int'(ras_push_o);
    checks++; if (pushes !== 1) begin failures++; $display("FAIL bp_push_count got=%0d exp=1", pushes); end
  endtask

  // Flush between JAL acceptance and delay-slot acceptance
  task automatic test_flush();
    drive(1'b1, 32'h00003000, 32'h0C000200);
    cyc();
    checks++; if (ras_push_o !== 1'b1) begin failures++; $display("FAIL flush_jal_push got=%0b exp=1", ras_push_o); end
    flush_i = 1'b1;
    drive(1'b1, 32'h00003004, 32'h00000000); #1;
    checks++; if (inst_ready_o !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", inst_ready_o); end
    cyc();
    flush_i = 1'b0;
    checks++; if (out_valid_o !== 1'b0 || ras_push_o !== 1'b0 || pred_redirect_o !== 1'b0)
      begin failures++; $display("FAIL flush_clear got=valid%0b push%0b redir%0b exp=0/0/0", out_valid_o, ras_push_o, pred_redirect_o); end
    drive(1'b1, 32'h00004000, 32'h08000010);
    cyc();
    checks++; if (out_pc_o !== 32'h00004000 || out_ds_o !== 1'b0 || pred_redirect_o !== 1'b0)
      begin failures++; $display("FAIL flush_j_decode got=%h ds%0b redir%0b exp=00004000/0/0", out_pc_o, out_ds_o, pred_redirect_o); end
    drive(1'b1, 32'h00004004, 32'h00000000);
    cyc();
    checks++; if (pred_redirect_o !== 1'b1 || pred_target_o !== 32'h00000040 || out_ds_o !== 1'b1)
      begin failures++; $display("FAIL flush_j_redirect got=%0b/%h ds%0b exp=1/00000040/1", pred_redirect_o, pred_target_o, out_ds_o); end
    drive(1'b0, 32'h0, 32'h0);
    cyc();
  endtask

  // Flush while waiting for the RAS: the pending return redirect never appears
  task automatic test_flush_ret();
    int redirs;
    redirs = 0;
    drive(1'b1, 32'h00005000, 32'h03E00008);
    cyc();
    drive(1'b1, 32'h00005004, 32'h00000000);
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    redirs += int'(pred_redirect_o);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0; #1;
    checks++; if (pred_redirect_o !== 1'b0) begin failures++; $display("FAIL flushret_suppressed got=%0b exp=0", pred_redirect_o); end
    checks++; if (inst_ready_o !== 1'b1) begin failures++; $display("FAIL flushret_ready got=%0b exp=1", inst_ready_o); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      redirs += int'(pred_redirect_o);
    end
    checks++; if (redirs !== 0) begin failures++; $display("FAIL flushret_count got=%0d exp=0", redirs); end
  endtask

  // J at 0xFFFFFFFC with a JAL in its delay slot
  task automatic test_wrap();
    drive(1'b1, 32'hFFFFFFFC, 32'h0BFFFFFF);
    cyc();
    checks++; if (ras_push_o !== 1'b0 || pred_redirect_o !== 1'b0) begin failures++; $display("FAIL wrap_j got=push%0b redir%0b exp=0/0", ras_push_o, pred_redirect_o); end
    drive(1'b1, 32'h00000000, 32'h0C000001);
    cyc();
    checks++; if (pred_redirect_o !== 1'b1 || pred_target_o !== 32'h0FFFFFFC) begin failures++; $display("FAIL wrap_target got=%0b/%h exp=1/0ffffffc", pred_redirect_o, pred_target_o); end
    checks++; if (out_ds_o !== 1'b1 || out_inst_o !== 32'h0C000001) begin failures++; $display("FAIL wrap_ds got=%0b/%h exp=1/0c000001", out_ds_o, out_inst_o); end
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    checks++; if (ras_push_o !== 1'b0 || pred_redirect_o !== 1'b0) begin failures++; $display("FAIL wrap_ds_jal_push got=push%0b redir%0b exp=0/0", ras_push_o, pred_redirect_o); end
  endtask

  // Asynchronous reset while a JAL is pending its delay slot
  task automatic test_async_reset();
    drive(1'b1, 32'h00006000, 32'h0C000300);
    cyc();
    checks++; if (ras_push_o !== 1'b1) begin failures++; $display("FAIL arst_pre_push got=%0b exp=1", ras_push_o); end
    drive(1'b0, 32'h0, 32'h0);
    #2 rst = 1'b0;
    #1;
    checks++; if (ras_push_o !== 1'b0 || out_valid_o !== 1'b0 || out_pc_o !== 32'h0)
      begin failures++; $display("FAIL arst_clear got=push%0b valid%0b pc=%h exp=0/0/0", ras_push_o, out_valid_o, out_pc_o); end
    @(negedge clk); rst = 1'b1;
    cyc();
    drive(1'b1, 32'h00007000, 32'h08000004);
    cyc();
    checks++; if (out_ds_o !== 1'b0 || out_pc_o !== 32'h00007000) begin failures++; $display("FAIL arst_idle got=ds%0b pc=%h exp=0/00007000", out_ds_o, out_pc_o); end
    drive(1'b1, 32'h00007004, 32'h00000000);
    cyc();
    checks++; if (pred_redirect_o !== 1'b1 || pred_target_o !== 32'h00000010) begin failures++; $display("FAIL arst_j_redirect got=%0b/%h exp=1/00000010", pred_redirect_o, pred_target_o); end
    drive(1'b0, 32'h0, 32'h0);
    cyc();
  endtask

  function automatic logic [31:0] rand_word();
    int unsigned k;
    logic [31:0] r;
    logic [4:0]  rs5, rd5;
    logic [5:0]  op6;
    k   = $urandom_range(0, 9);
    r   = $urandom;
    rs5 = 5'($urandom_range(0, 30));
    rd5 = 5'($urandom_range(0, 31));
    op6 = 6'($urandom_range(4, 63));
    case (k)
      0: rand_word = {6'd2, r[25:0]};
      1: rand_word = {6'd3, r[25:0]};
      2: rand_word = {6'd0, 5'd31, 15'd0, 6'd8};
      3: rand_word = {6'd0, rs5, 15'd0, 6'd8};
      4: rand_word = {6'd0, 5'd31, 5'd0, rd5, 5'd0, 6'd9};
      5: rand_word = {6'd0, rs5, 5'd0, rd5, 5'd0, 6'd9};
      6: rand_word = {6'd1, r[25:21], 4'b1000, r[16], r[15:0]};
      7: rand_word = {6'd1, r[25:21], 4'b0000, r[16], r[15:0]};
      default: rand_word = {op6, r[25:0]};
    endcase
  endfunction

  // Random instruction stream under random valid/ready, checked in order
  // against a transaction-level model of the predecode rules.
  task automatic test_random();
    logic [31:0] words[$];
    logic [31:0] pcs[$];
    logic [64:0] exp_out[$];
    logic [31:0] exp_push[$];
    logic [32:0] exp_redir[$];
    int          exp_pops;
    logic [31:0] pc, w, p;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt;
    logic        ds_pend, accepted;
    logic [32:0] pend;
    int          waited;

    pc = $urandom & 32'hFFFFFFFC;
    for (int i = 0; i < 150; i++) begin
      words.push_back(rand_word());
      pcs.push_back(pc);
      pc = pc + 32'd4;
    end

    exp_pops = 0;
    ds_pend  = 1'b0;
    pend     = '0;
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      p = pcs[i];
      if (ds_pend) begin
        exp_out.push_back({1'b1, p, w});
        exp_redir.push_back(pend);
        ds_pend = 1'b0;
      end else begin
        exp_out.push_back({1'b0, p, w});
        op = w[31:26]; rs = w[25:21]; rt = w[20:16]; funct = w[5:0];
        if (op == 6'd3 || (op == 6'd0 && funct == 6'd9) || (op == 6'd1 && rt[4:1] == 4'b1000))
          exp_push.push_back(p + 32'd8);
        if (op == 6'd0 && (funct == 6'd8 || funct == 6'd9) && rs == 5'd31)
          exp_pops++;
        if (op == 6'd2 || op == 6'd3) begin
          ds_pend = 1'b1;
          pend    = {1'b0, ((p + 32'd4) & 32'hF0000000) | ((w & 32'h03FFFFFF) << 2)};
        end else if (op == 6'd0 && funct == 6'd8 && rs == 5'd31) begin
          ds_pend = 1'b1;
          pend    = {1'b1, 32'h0};
        end
      end
      if (ds_pend && i == words.size() - 1) begin
        words.push_back(32'h00000000);
        pcs.push_back(p + 32'd4);
      end
    end

    got_out.delete(); got_push.delete(); got_redir.delete(); got_pops = 0;
    mon_on = 1'b1;
    for (int i = 0; i < words.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 32'h0, 32'h0);
        out_ready_i = 1'($urandom_range(0, 1));
        cyc();
      end
      drive(1'b1, pcs[i], words[i]);
      accepted = 1'b0;
      waited   = 0;
      while (!accepted && waited < 60) begin
        out_ready_i = ($urandom_range(0, 3) != 0);
        #1;
        accepted = inst_ready_o;
        cyc();
        waited++;
      end
      checks++;
      if (!accepted) begin
        failures++;
        $display("FAIL rand_accept_timeout word=%0d got=not accepted exp=accepted within 60 cycles", i);
        break;
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    out_ready_i = 1'b1;
    repeat (12) cyc();
    mon_on = 1'b0;

    checks++; if (got_out.size() != exp_out.size()) begin failures++; $display("FAIL rand_out_count got=%0d exp=%0d", got_out.size(), exp_out.size()); end
    for (int i = 0; i < exp_out.size() && i < got_out.size(); i++) begin
      checks++; if (got_out[i] !== exp_out[i]) begin failures++; $display("FAIL rand_out[%0d] got=%h exp=%h", i, got_out[i], exp_out[i]); end
    end
    checks++; if (got_push.size() != exp_push.size()) begin failures++; $display("FAIL rand_push_count got=%0d exp=%0d", got_push.size(), exp_push.size()); end
    for (int i = 0; i < exp_push.size() && i < got_push.size(); i++) begin
      checks++; if (got_push[i] !== exp_push[i]) begin failures++; $display("FAIL rand_push[%0d] got=%h exp=%h", i, got_push[i], exp_push[i]); end
    end
    checks++; if (got_pops != exp_pops) begin failures++; $display("FAIL rand_pop_count got=%0d exp=%0d", got_pops, exp_pops); end
    checks++; if (got_redir.size() != exp_redir.size()) begin failures++; $display("FAIL rand_redirect_count got=%0d exp=%0d", got_redir.size(), exp_redir.size()); end
    for (int i = 0; i < exp_redir.size() && i < got_redir.size(); i++) begin
      checks++; if (got_redir[i] !== exp_redir[i]) begin failures++; $display("FAIL rand_redirect[%0d] got=%h exp=%h", i, got_redir[i], exp_redir[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_jr();
    test_jalr_bal();
    test_backpressure();
    test_flush();
    test_flush_ret();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
